wb_regfile: RTL

General-purpose register file at the write-back end of the pipeline: 32 × 32-bit MIPS registers, one synchronous write port and two combinational read ports. The write port is the landing point for the execute stage's (wd, wreg, wdata) triple once it has passed the pipeline registers. The two read ports feed the decode stage with the rs/rt operands that decode forwards to execute as reg1/reg2.

---
 rtl/wb_regfile_pkg.sv | 18 +
 rtl/wb_regfile_if.sv | 27 ++
 rtl/wb_regfile_rdport.sv | 42 ++++
 rtl/wb_regfile.sv | 61 ++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the write-back register file: bus widths,
// the zero word and the polarity of the enable/reset strobes.
package wb_regfile_pkg;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;
   localparam int DEPTH   = 32;
   localparam int REG_NUM = 32;

   typedef logic [DATA_W-1:0] register_bus_t;
   typedef logic [ADDR_W-1:0] register_address_bus_t;

   localparam register_bus_t ZERO_WORD    = '0;
   localparam logic          RESET_ENABLE = 1'b1;
   localparam logic          WRITE_ENABLE = 1'b1;
   localparam logic          READ_ENABLE  = 1'b1;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_if.sv
// Write-back register file bus: one write port and two read ports.
// The master drives addresses, enables and write data; the slave returns read data.
interface wb_regfile_if;

   logic                                  we;
   wb_regfile_pkg::register_address_bus_t waddr;
   wb_regfile_pkg::register_bus_t         wdata;
   logic                                  re1;
   wb_regfile_pkg::register_address_bus_t raddr1;
   wb_regfile_pkg::register_bus_t         rdata1;
   logic                                  re2;
   wb_regfile_pkg::register_address_bus_t raddr2;
   wb_regfile_pkg::register_bus_t         rdata2;

   modport master (
      output we, waddr, wdata,
      output re1, raddr1, re2, raddr2,
      input  rdata1, rdata2
   );

   modport slave (
      input  we, waddr, wdata,
      input  re1, raddr1, re2, raddr2,
      output rdata1, rdata2
   );

endinterface : wb_regfile_if

// File: rtl/wb_regfile_rdport.sv
// One combinational read port of the register file.
// Define WB_REGFILE_BYPASS_EN to forward same-cycle write data to this port.
module wb_regfile_rdport
   import wb_regfile_pkg::*;
(
   input  logic                  rst,
   input  logic                  re,
   input  register_address_bus_t raddr,
   input  register_bus_t         stored,
`ifdef WB_REGFILE_BYPASS_EN
   input  logic                  we,
   input  register_address_bus_t waddr,
   input  register_bus_t         wdata,
`endif
   output register_bus_t         rdata
);

`ifdef WB_REGFILE_BYPASS_EN
   logic bypass_hit;

   assign bypass_hit = (we == WRITE_ENABLE) && (waddr != '0) &&
                       (re == READ_ENABLE) && (raddr == waddr) &&
                       (rst != RESET_ENABLE);
`endif

   always_comb begin
      // NOTE: default assignment first so every path drives rdata; no latch inferred.
      rdata = ZERO_WORD;
      if (rst == RESET_ENABLE) begin
         rdata = ZERO_WORD;
      end else if (raddr == '0) begin
         rdata = ZERO_WORD;
`ifdef WB_REGFILE_BYPASS_EN
      end else if (bypass_hit) begin
         rdata = wdata;
`endif
      end else if (re == READ_ENABLE) begin
         rdata = stored;
      end
   end

endmodule : wb_regfile_rdport

// File: rtl/wb_regfile.sv
// 32 x 32-bit MIPS register file: synchronous write, two combinational reads.
// Optional write-to-read bypass is selected with WB_REGFILE_BYPASS_EN.
module wb_regfile
   import wb_regfile_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   wb_regfile_if.slave  bus
);

   register_bus_t regs_q [DEPTH];
   register_bus_t regs_d [DEPTH];

   always_comb begin
      regs_d = regs_q;
      if ((bus.we == WRITE_ENABLE) && (bus.waddr != '0)) begin
         regs_d[bus.waddr] = bus.wdata;
      end
      regs_d[0] = ZERO_WORD;
   end

   // NOTE: the array is reset explicitly because software expects r1..r31 to read
   // zero right after reset; this is a flop array, not an inferred RAM.
   always_ff @(posedge clk) begin
      if (rst == RESET_ENABLE) begin
         for (int i = 0; i < DEPTH; i++) begin
            // NOTE: non-blocking for all sequential state so every reader sees pre-edge values.
            regs_q[i] <= ZERO_WORD;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   wb_regfile_rdport u_rdport1 (
      .rst    (rst),
      .re     (bus.re1),
      .raddr  (bus.raddr1),
      .stored (regs_q[bus.raddr1]),
`ifdef WB_REGFILE_BYPASS_EN
      .we     (bus.we),
      .waddr  (bus.waddr),
      .wdata  (bus.wdata),
`endif
      .rdata  (bus.rdata1)
   );

   wb_regfile_rdport u_rdport2 (
      .rst    (rst),
      .re     (bus.re2),
      .raddr  (bus.raddr2),
      .stored (regs_q[bus.raddr2]),
`ifdef WB_REGFILE_BYPASS_EN
      .we     (bus.we),
      .waddr  (bus.waddr),
      .wdata  (bus.wdata),
`endif
      .rdata  (bus.rdata2)
   );

endmodule : wb_regfile
